// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file controller: op codes, FSM
// state encodings and the default register-file geometry.
package regfile_ctrl_pkg;

  // Default geometry of the attached register file
  localparam int N_DEF = 8;
  localparam int R_DEF = 32;

  // Host command op codes
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_DUMP  = 2'b11;

  // Controller FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WR     = 3'd1;
  localparam logic [2:0] ST_FILL   = 3'd2;
  localparam logic [2:0] ST_RD_REQ = 3'd3;
  localparam logic [2:0] ST_RD_CAP = 3'd4;
  localparam logic [2:0] ST_RSP    = 3'd5;

endpackage

// File: rtl/regfile_ctrl.sv
// Initiator-side controller for an N x R register file. Accepts one host
// command at a time (read, write, fill-all, dump-all), sequences the file's
// write/read pins and returns read data on a valid/ready response port.
// Reads and writes are never issued in the same cycle.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int R  = R_DEF,
  parameter int RR = $clog2(R)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [RR-1:0] cmd_addr,
  input  logic [N-1:0]  cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_data,
  output logic [RR-1:0] rsp_addr,
  output logic          rsp_last,
  output logic          rf_wr,
  output logic [RR-1:0] rf_reg_id_w,
  output logic [RR-1:0] rf_reg_id_r,
  output logic [N-1:0]  rf_data_in,
  input  logic [N-1:0]  rf_data_out
);

  localparam logic [RR-1:0] LAST_IDX = RR'(R - 1);

  logic [2:0]    state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [RR-1:0] cnt_q, cnt_d;
  logic          rf_wr_q, rf_wr_d;
  logic [RR-1:0] rf_reg_id_w_q, rf_reg_id_w_d;
  logic [RR-1:0] rf_reg_id_r_q, rf_reg_id_r_d;
  logic [N-1:0]  rf_data_in_q, rf_data_in_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [N-1:0]  rsp_data_q, rsp_data_d;
  logic [RR-1:0] rsp_addr_q, rsp_addr_d;
  logic          rsp_last_q, rsp_last_d;

  // Accept only in IDLE; rst forces ready low in the same cycle
  assign cmd_ready = (state_q == ST_IDLE) && !rst;

  // Next-state logic; all file pins are precomputed here and registered so
  // nothing on the command port reaches the file combinationally
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    rf_wr_d       = 1'b0;
    rf_reg_id_w_d = rf_reg_id_w_q;
    rf_reg_id_r_d = rf_reg_id_r_q;
    rf_data_in_d  = rf_data_in_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_addr_d    = rsp_addr_q;
    rsp_last_d    = rsp_last_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d = cmd_op;
          case (cmd_op)
            OP_WRITE: begin
              state_d       = ST_WR;
              rf_wr_d       = 1'b1;
              rf_reg_id_w_d = cmd_addr;
              rf_data_in_d  = cmd_data;
            end
            OP_FILL: begin
              state_d       = ST_FILL;
              cnt_d         = '0;
              rf_wr_d       = 1'b1;
              rf_reg_id_w_d = '0;
              rf_data_in_d  = cmd_data;
            end
            OP_READ: begin
              state_d       = ST_RD_REQ;
              cnt_d         = cmd_addr;
              rf_reg_id_r_d = cmd_addr;
            end
            default: begin
              state_d       = ST_RD_REQ;
              cnt_d         = '0;
              rf_reg_id_r_d = '0;
            end
          endcase
        end
      end
      ST_WR: state_d = ST_IDLE;
      ST_FILL: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d         = cnt_q + RR'(1);
          rf_wr_d       = 1'b1;
          rf_reg_id_w_d = cnt_q + RR'(1);
        end
      end
      ST_RD_REQ: state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        // File output is valid this cycle (one-cycle registered read)
        rsp_valid_d = 1'b1;
        rsp_data_d  = rf_data_out;
        rsp_addr_d  = cnt_q;
        rsp_last_d  = (op_q == OP_READ) || (cnt_q == LAST_IDX);
        state_d     = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rsp_last_q) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d         = cnt_q + RR'(1);
            rf_reg_id_r_d = cnt_q + RR'(1);
            state_d       = ST_RD_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_READ;
      cnt_q         <= '0;
      rf_wr_q       <= 1'b0;
      rf_reg_id_w_q <= '0;
      rf_reg_id_r_q <= '0;
      rf_data_in_q  <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_addr_q    <= '0;
      rsp_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      rf_wr_q       <= rf_wr_d;
      rf_reg_id_w_q <= rf_reg_id_w_d;
      rf_reg_id_r_q <= rf_reg_id_r_d;
      rf_data_in_q  <= rf_data_in_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_addr_q    <= rsp_addr_d;
      rsp_last_q    <= rsp_last_d;
    end
  end

  assign rf_wr       = rf_wr_q;
  assign rf_reg_id_w = rf_reg_id_w_q;
  assign rf_reg_id_r = rf_reg_id_r_q;
  assign rf_data_in  = rf_data_in_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_last    = rsp_last_q;

endmodule
